// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder-sharing arbiter: data widths and FSM state encoding.
package decoder_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/decoder_share_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request strictly after 'last', wrapping to bit 0.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_i,
  output logic [N_REQ-1:0] win_o,
  output logic [ID_W-1:0]  win_idx_o
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] hi_req;
  logic [N_REQ-1:0] pick_src;
  logic             found;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (i > 32'(last_i)) mask[i] = 1'b1;
    end
    hi_req   = req_i & mask;
    // Nothing above the pointer: wrap and take the lowest request overall.
    pick_src = (|hi_req) ? hi_req : req_i;

    win_o     = '0;
    win_idx_o = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_src[i] && !found) begin
        win_o[i]  = 1'b1;
        win_idx_o = ID_W'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_share_arbiter.sv
// Round-robin sharing of one registered 3-to-8 decoder; one operation in flight at a time.
module decoder_share_arbiter
  import decoder_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int DEC_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*SEL_W-1:0] req_sel,
  output logic [N_REQ-1:0]       gnt,
  output logic [SEL_W-1:0]       dec_sel,
  input  logic [OUT_W-1:0]       dec_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [OUT_W-1:0]       rsp_data,
  output logic                   busy
);

  state_t             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [SEL_W-1:0]   dec_sel_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [OUT_W-1:0]   rsp_data_q;
  logic [ID_W-1:0]    last_q;
  logic [LAT_W-1:0]   lat_cnt_q;

  logic [N_REQ-1:0]   win;
  logic [ID_W-1:0]    win_idx;
  logic [SEL_W-1:0]   win_sel;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i     (req),
    .last_i    (last_q),
    .win_o     (win),
    .win_idx_o (win_idx)
  );

  always_comb begin
    win_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win[i]) win_sel = req_sel[i*SEL_W +: SEL_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      dec_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      last_q      <= ID_W'(N_REQ - 1);
      lat_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            gnt_q     <= win;
            dec_sel_q <= win_sel;
            rsp_id_q  <= win_idx;
            last_q    <= win_idx;
            lat_cnt_q <= LAT_W'(DEC_LAT);
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          gnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          if (lat_cnt_q == LAT_W'(1)) begin
            rsp_data_q  <= dec_out;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign dec_sel   = dec_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_decoder_share_arbiter.sv
// Self-checking bench: vector table plus hand sequences, responses checked via a scoreboard queue.
module tb_decoder_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [11:0] req_sel = '0;
  logic [3:0]  gnt;
  logic [2:0]  dec_sel;
  logic [7:0]  dec_out;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;

  logic [3:0]  req3 = '0;
  logic [11:0] req_sel3 = '0;
  logic [3:0]  gnt3;
  logic [2:0]  dec_sel3;
  logic [7:0]  dec_out3;
  logic        rsp_valid3;
  logic        rsp_ready3 = 1'b1;
  logic [1:0]  rsp_id3;
  logic [7:0]  rsp_data3;
  logic        busy3;
  logic [7:0]  p3a, p3b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [3:0]  req;
    logic [11:0] sel;
    logic [1:0]  exp_id;
    logic [2:0]  exp_sel;
    logic [7:0]  exp_data;
  } vec_t;
  vec_t vt[7];

  always #5 clk = ~clk;

  decoder_share_arbiter #(.N_REQ(4), .ID_W(2), .DEC_LAT(1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_sel(req_sel), .gnt(gnt), .dec_sel(dec_sel),
    .dec_out(dec_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  decoder_share_arbiter #(.N_REQ(4), .ID_W(2), .DEC_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .req_sel(req_sel3), .gnt(gnt3), .dec_sel(dec_sel3),
    .dec_out(dec_out3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
    .rsp_data(rsp_data3), .busy(busy3)
  );

  // Registered 3-to-8 decoder models: one stage, and three stages for the DEC_LAT=3 instance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_out  <= '0;
      p3a      <= '0;
      p3b      <= '0;
      dec_out3 <= '0;
    end else begin
      dec_out  <= 8'd1 << dec_sel;
      p3a      <= 8'd1 << dec_sel3;
      p3b      <= p3a;
      dec_out3 <= p3b;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // Response monitor: pops the scoreboard on every accepted response.
  always begin
    @(negedge clk);
    #1;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        fail_now("rsp_unexpected");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_rsp_id", 32'(rsp_id), 32'(e.id));
        chk("sb_rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  task automatic wait_gnt(input string name, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (n < 20 && !ok) begin
      @(negedge clk);
      n++;
      if (gnt != '0) ok = 1'b1;
    end
    if (!ok) fail_now({name, "_gnt_timeout"});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now({name, "_idle_timeout"});
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    bit ok;
    req     = v.req;
    req_sel = v.sel;
    wait_gnt(tag, n, ok);
    if (!ok) return;
    chk({tag, "_gnt"}, 32'(gnt), 32'(1) << v.exp_id);
    chk({tag, "_gnt_latency"}, 32'(n), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    req = '0;
    sbq.push_back('{id: v.exp_id, data: v.exp_data});
    @(negedge clk);
    chk({tag, "_gnt_pulse"}, 32'(gnt), 32'd0);
    chk({tag, "_dec_sel"}, 32'(dec_sel), 32'(v.exp_sel));
    chk({tag, "_valid_early"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_dec_sel_hold"}, 32'(dec_sel), 32'(v.exp_sel));
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g1cnt;
    bit ok;
    vec_t v;

    vt[0] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd5}, 2'd0, 3'd5, 8'h20};
    vt[1] = '{4'b0100, {3'd0, 3'd3, 3'd0, 3'd0}, 2'd2, 3'd3, 8'h08};
    vt[2] = '{4'b0011, {3'd0, 3'd0, 3'd7, 3'd0}, 2'd0, 3'd0, 8'h01};
    vt[3] = '{4'b1010, {3'd6, 3'd0, 3'd2, 3'd0}, 2'd1, 3'd2, 8'h04};
    vt[4] = '{4'b1001, {3'd4, 3'd0, 3'd0, 3'd1}, 2'd3, 3'd4, 8'h10};
    vt[5] = '{4'b1001, {3'd4, 3'd0, 3'd0, 3'd1}, 2'd0, 3'd1, 8'h02};
    vt[6] = '{4'b1000, {3'd7, 3'd0, 3'd0, 3'd0}, 2'd3, 3'd7, 8'h80};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_dec_sel", 32'(dec_sel), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_gnt", 32'(gnt), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // All four requesting continuously: rotation 0,1,2,3,0 with 4-cycle spacing
    req     = 4'b1111;
    req_sel = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int k = 0; k < 5; k++) begin
      wait_gnt($sformatf("rot%0d", k), n, ok);
      if (ok) begin
        chk($sformatf("rot%0d_gnt", k), 32'(gnt), 32'(1) << (k % 4));
        if (k > 0) chk($sformatf("rot%0d_gap", k), 32'(n), 32'd4);
        sbq.push_back('{id: 2'(k % 4), data: 8'd1 << ((k % 4) + 1)});
      end
    end
    req = '0;
    wait_idle("rot");

    // Stall in RESP for 10 cycles with a competing request pending
    rsp_ready = 1'b0;
    req       = 4'b0010;
    req_sel   = {3'd0, 3'd0, 3'd6, 3'd0};
    wait_gnt("stall", n, ok);
    chk("stall_gnt", 32'(gnt), 32'b0010);
    req = 4'b0100;
    req_sel = {3'd0, 3'd2, 3'd6, 3'd0};
    sbq.push_back('{id: 2'd1, data: 8'h40});
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) fail_now("stall_valid_timeout");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_id", 32'(rsp_id), 32'd1);
      chk("stall_data", 32'(rsp_data), 32'h40);
      chk("stall_no_gnt", 32'(gnt), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    wait_gnt("after_stall", n, ok);
    chk("after_stall_gnt", 32'(gnt), 32'b0100);
    chk("after_stall_latency", 32'(n), 32'd2);
    req = '0;
    sbq.push_back('{id: 2'd2, data: 8'h04});
    wait_idle("after_stall");

    // Reset while in WAIT discards the operation and restores the pointer
    req     = 4'b0001;
    req_sel = {3'd0, 3'd0, 3'd0, 3'd5};
    wait_gnt("midrst", n, ok);
    chk("midrst_gnt", 32'(gnt), 32'b0001);
    req = '0;
    @(negedge clk);
    chk("midrst_busy_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_gnt0", 32'(gnt), 32'd0);
    chk("midrst_valid0", 32'(rsp_valid), 32'd0);
    chk("midrst_busy0", 32'(busy), 32'd0);
    chk("midrst_dec_sel0", 32'(dec_sel), 32'd0);
    chk("midrst_id0", 32'(rsp_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle_valid", 32'(rsp_valid), 32'd0);
    v = '{4'b0101, {3'd0, 3'd3, 3'd0, 3'd1}, 2'd0, 3'd1, 8'h02};
    run_vec(v, "ptr_reset");
    v = '{4'b0100, {3'd0, 3'd3, 3'd0, 3'd0}, 2'd2, 3'd3, 8'h08};
    run_vec(v, "post_rst_req2");

    // req[1] pulses while busy and drops: never granted, pointer untouched
    req     = 4'b0001;
    req_sel = {3'd0, 3'd0, 3'd0, 3'd2};
    wait_gnt("pulse", n, ok);
    chk("pulse_gnt", 32'(gnt), 32'b0001);
    req = '0;
    sbq.push_back('{id: 2'd0, data: 8'h04});
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    g1cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (gnt != '0) g1cnt++;
    end
    chk("pulse_never_granted", 32'(g1cnt), 32'd0);
    chk("pulse_idle", 32'(busy), 32'd0);
    v = '{4'b0110, {3'd0, 3'd5, 3'd3, 3'd0}, 2'd1, 3'd3, 8'h08};
    run_vec(v, "pulse_ptr");

    // DEC_LAT=3 instance: response one capture four edges after the grant edge
    req3     = 4'b0100;
    req_sel3 = {3'd0, 3'd3, 3'd0, 3'd0};
    n  = 0;
    ok = 1'b0;
    while (n < 20 && !ok) begin
      @(negedge clk);
      n++;
      if (gnt3 != '0) ok = 1'b1;
    end
    if (!ok) fail_now("lat3_gnt_timeout");
    chk("lat3_gnt", 32'(gnt3), 32'b0100);
    req3 = '0;
    n = 0;
    ok = 1'b0;
    while (n < 20 && !ok) begin
      @(negedge clk);
      n++;
      if (rsp_valid3) ok = 1'b1;
    end
    if (!ok) fail_now("lat3_valid_timeout");
    chk("lat3_latency", 32'(n), 32'd4);
    chk("lat3_id", 32'(rsp_id3), 32'd2);
    chk("lat3_data", 32'(rsp_data3), 32'h08);
    chk("lat3_dec_sel", 32'(dec_sel3), 32'd3);
    @(negedge clk);
    chk("lat3_valid_drop", 32'(rsp_valid3), 32'd0);
    chk("lat3_busy_end", 32'(busy3), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
